// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative integer multiply/divide unit with HI/LO result registers.
//   Multiplication uses one shift-add step per cycle. Division uses one
//   restoring subtract-shift step per cycle. Both run on operand
//   magnitudes, and a final FIX cycle restores the signs.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset
//   start     launch the operation selected by op with operands a/b
//   op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a, b      operands (a is also the MTHI/MTLO source)
//   cancel    flush: abort any in-flight operation, suppress its write
//   hi, lo    result registers (product high/low, remainder/quotient)
//   busy      operation in flight (stall request)
//   done      one-cycle pulse when a MULT/DIV result lands in hi/lo
//   div_zero  last divide had a zero divisor; cleared by the next long op

module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cancel,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;

    // acc_hi:acc_lo is the product accumulator for multiply, and the
    // remainder:quotient pair for divide. opnd holds the addend
    // (multiplicand magnitude) or the divisor magnitude.
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] a_q;
    logic              is_div_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic              b_zero_q;

    logic              accept;
    logic              signed_op;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic [DATA_W-1:0] step_hi;
    logic [DATA_W-1:0] step_lo;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    // A long op (op[2]==0) is accepted only from IDLE, and only when
    // cancel is not asserted in the same cycle.
    assign accept    = (state == IDLE) && start && !cancel;
    assign signed_op = !op[0];
    assign mag_a     = (signed_op && a[DATA_W-1]) ? -a : a;
    assign mag_b     = (signed_op && b[DATA_W-1]) ? -b : b;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Cancel returns to IDLE from either working state.
    // The counter reaching 1 marks the last CALC step.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && !cancel && !op[2]) next_state = CALC;
            CALC: begin
                if (cancel)                    next_state = IDLE;
                else if (cnt == CNT_W'(1))     next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state != IDLE);
    end

    // One iteration step, for both multiply and restoring divide.
    // Multiply adds opnd when the multiplier LSB is set, then shifts the
    // pair right. Divide shifts the next dividend bit into the remainder
    // and keeps the subtraction when it does not borrow. Because the
    // remainder stays below the divisor, div_diff[DATA_W] is the borrow.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        step_hi   = mul_sum[DATA_W:1];
        step_lo   = {mul_sum[0], acc_lo[DATA_W-1:1]};
        if (is_div_q) begin
            if (!div_diff[DATA_W]) begin
                step_hi = div_diff[DATA_W-1:0];
                step_lo = {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                step_hi = div_shift[DATA_W-1:0];
                step_lo = {acc_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Sign correction applied in FIX. The quotient and product take the
    // XOR of the operand signs, and the remainder follows the dividend.
    // A zero divisor returns the original dividend and an all-ones
    // quotient. Most-negative / -1 needs no special case: its magnitude
    // quotient is already the most-negative pattern.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = neg_a_q ? -acc_hi : acc_hi;
                res_lo = (neg_a_q ^ neg_b_q) ? -acc_lo : acc_lo;
            end
        end else if (neg_a_q ^ neg_b_q) begin
            prod   = -prod;
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end
    end

    // Datapath and architectural registers.
    // In IDLE, start loads operands (long ops) or writes hi/lo directly
    // (MTHI/MTLO). CALC runs the iteration. FIX commits the result,
    // unless cancel arrives in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !op[2]) begin
                        a_q      <= a;
                        is_div_q <= op[1];
                        neg_a_q  <= signed_op && a[DATA_W-1];
                        neg_b_q  <= signed_op && b[DATA_W-1];
                        b_zero_q <= (b == '0);
                        acc_hi   <= '0;
                        acc_lo   <= op[1] ? mag_a : mag_b;
                        opnd     <= op[1] ? mag_b : mag_a;
                        cnt      <= CNT_W'(DATA_W);
                        div_zero <= 1'b0;
                    end else if (accept && op == OP_MTHI) begin
                        hi <= a;
                    end else if (accept && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (!cancel) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                        if (is_div_q && b_zero_q) div_zero <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
